// File: rtl/adc_lane_align.sv
// rtl/adc_lane_align.sv - per-lane SERDES word alignment via bitslip training
module adc_lane_align #(
  parameter int             N_LANE      = 8,
  parameter int             W           = 8,
  parameter logic [W-1:0]   PATTERN     = 8'hF0,
  parameter int             MATCH_COUNT = 16,
  parameter int             SLIP_WAIT   = 3
) (
  input  logic                ref_clk,
  input  logic                ref_rst_n,
  input  logic [N_LANE-1:0]   rx_locked,
  input  logic                start,
  input  logic [N_LANE*W-1:0] lane_data,
  output logic [N_LANE-1:0]   bitslip,
  output logic [N_LANE-1:0]   aligned,
  output logic [N_LANE-1:0]   error,
  output logic                all_aligned,
  output logic [N_LANE*W-1:0] data_out,
  output logic                data_valid
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = (W > 2) ? $clog2(W) : 1;
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SLIP_LAST  = SW'(W - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_CHECK, S_SLIP, S_SETTLE, S_ALIGNED, S_FAIL
  } state_t;

  logic [N_LANE*W-1:0] data_out_q;
  logic                data_valid_q;

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    state_t        state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic [SW-1:0] slip_q,  slip_d;
    logic [WW-1:0] wait_q,  wait_d;
    logic [W-1:0]  word;

    assign word = lane_data[i*W +: W];

    // Lane state and training counters
    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
      if (!ref_rst_n) begin
        state_q <= S_IDLE;
        match_q <= '0;
        slip_q  <= '0;
        wait_q  <= '0;
      end else begin
        state_q <= state_d;
        match_q <= match_d;
        slip_q  <= slip_d;
        wait_q  <= wait_d;
      end
    end

    // Next state: start beats lock loss beats the normal training flow
    always_comb begin
      state_d = state_q;
      match_d = match_q;
      slip_d  = slip_q;
      wait_d  = wait_q;
      if (start) begin
        state_d = S_WAIT_LOCK;
        match_d = '0;
        slip_d  = '0;
        wait_d  = '0;
      end else if (!rx_locked[i] &&
                   (state_q inside {S_CHECK, S_SLIP, S_SETTLE, S_ALIGNED})) begin
        state_d = S_WAIT_LOCK;
        match_d = '0;
        slip_d  = '0;
        wait_d  = '0;
      end else begin
        case (state_q)
          S_WAIT_LOCK: begin
            match_d = '0;
            slip_d  = '0;
            wait_d  = '0;
            if (rx_locked[i]) state_d = S_CHECK;
          end
          S_CHECK: begin
            if (word == PATTERN) begin
              match_d = match_q + 1'b1;
              if (match_q == MATCH_LAST) state_d = S_ALIGNED;
            end else begin
              match_d = '0;
              state_d = (slip_q == SLIP_LAST) ? S_FAIL : S_SLIP;
            end
          end
          S_SLIP: begin
            slip_d  = slip_q + 1'b1;
            wait_d  = '0;
            state_d = S_SETTLE;
          end
          S_SETTLE: begin
            if (wait_q == WAIT_LAST) begin
              wait_d  = '0;
              state_d = S_CHECK;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Outputs decode straight from the state register, so reset clears them at once
    assign bitslip[i] = (state_q == S_SLIP);
    assign aligned[i] = (state_q == S_ALIGNED);
    assign error[i]   = (state_q == S_FAIL);
  end

  assign all_aligned = &aligned;

  // Sample pipeline: data and valid share one register stage
  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= lane_data;
      data_valid_q <= all_aligned;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_adc_lane_align.sv
// tb/tb_adc_lane_align.sv - directed self-checking bench for adc_lane_align
module tb_adc_lane_align;

  localparam int N = 8;

  logic          ref_clk = 1'b0;
  logic          ref_rst_n;
  logic [N-1:0]  rx_locked;
  logic          start;
  logic [N*8-1:0] lane_data;
  logic [N-1:0]  bitslip, aligned, error;
  logic          all_aligned, data_valid;
  logic [N*8-1:0] data_out;

  adc_lane_align dut (
    .ref_clk(ref_clk), .ref_rst_n(ref_rst_n), .rx_locked(rx_locked), .start(start),
    .lane_data(lane_data), .bitslip(bitslip), .aligned(aligned), .error(error),
    .all_aligned(all_aligned), .data_out(data_out), .data_valid(data_valid)
  );

  always #5 ref_clk = ~ref_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap_bad = 0;
  int slips [N];
  int need [N];
  int last_slip [N];
  logic       force_en [N];
  logic [7:0] force_word [N];
  logic [N*8-1:0] prev_data;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      if (force_en[i]) lane_data[i*8 +: 8] = force_word[i];
      else if (slips[i] >= need[i]) lane_data[i*8 +: 8] = 8'hF0;
      else lane_data[i*8 +: 8] = rotl(8'hF0, need[i] - slips[i]);
    end
  endtask

  task automatic step();
    for (int i = 0; i < N; i++) begin
      if (bitslip[i]) begin
        if (last_slip[i] >= 0 && (cyc - last_slip[i]) != 5) gap_bad++;
        last_slip[i] = cyc;
        slips[i]++;
      end
    end
    drive_data();
    prev_data = lane_data;
    @(posedge ref_clk);
    @(negedge ref_clk);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_start();
    for (int i = 0; i < N; i++) last_slip[i] = -1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    steps(2);
    checks++; if (bitslip !== 8'h00 || aligned !== 8'h00 || error !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got bs=%h al=%h er=%h expected 00 00 00", bitslip, aligned, error); end
    checks++; if (all_aligned !== 1'b0 || data_valid !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL reset_data: got aa=%b dv=%b do=%h expected 0 0 0", all_aligned, data_valid, data_out); end
    ref_rst_n = 1'b1;
    steps(5);
    checks++; if (aligned !== 8'h00 || slips[0] !== 0) begin
      errors++; $display("FAIL idle_no_start: got al=%h slips0=%0d expected 00 0", aligned, slips[0]); end
  endtask

  task automatic test_all_aligned();
    pulse_start();
    steps(16);
    checks++; if (aligned !== 8'h00) begin
      errors++; $display("FAIL aligned_early: got %h expected 00", aligned); end
    step();
    checks++; if (aligned !== 8'hFF || all_aligned !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL aligned_t17: got al=%h aa=%b dv=%b expected ff 1 0", aligned, all_aligned, data_valid); end
    step();
    checks++; if (data_valid !== 1'b1) begin
      errors++; $display("FAIL valid_lag: got %b expected 1", data_valid); end
    checks++; if (slips[0] + slips[3] + slips[7] !== 0) begin
      errors++; $display("FAIL no_slips: got %0d expected 0", slips[0] + slips[3] + slips[7]); end
  endtask

  task automatic test_slip_lane2();
    need[2] = 3; slips[2] = 0;
    pulse_start();
    steps(17);
    checks++; if (aligned !== 8'hFB) begin
      errors++; $display("FAIL slip2_others: got %h expected fb", aligned); end
    steps(14);
    checks++; if (aligned !== 8'hFB) begin
      errors++; $display("FAIL slip2_t31: got %h expected fb", aligned); end
    step();
    checks++; if (aligned !== 8'hFF) begin
      errors++; $display("FAIL slip2_t32: got %h expected ff", aligned); end
    checks++; if (slips[2] !== 3 || slips[1] !== 0 || gap_bad !== 0) begin
      errors++; $display("FAIL slip2_count: got slips=%0d lane1=%0d gapbad=%0d expected 3 0 0", slips[2], slips[1], gap_bad); end
  endtask

  task automatic test_fail_lane5();
    force_en[5] = 1'b1; force_word[5] = 8'h00; slips[5] = 0;
    pulse_start();
    steps(36);
    checks++; if (error !== 8'h00) begin
      errors++; $display("FAIL fail5_early: got %h expected 00", error); end
    step();
    checks++; if (error !== 8'h20 || aligned !== 8'hDF) begin
      errors++; $display("FAIL fail5_t37: got er=%h al=%h expected 20 df", error, aligned); end
    steps(3);
    checks++; if (slips[5] !== 7 || gap_bad !== 0 || all_aligned !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL fail5_state: got slips=%0d gapbad=%0d aa=%b dv=%b expected 7 0 0 0", slips[5], gap_bad, all_aligned, data_valid); end
    force_en[5] = 1'b0;
    pulse_start();
    checks++; if (error !== 8'h00) begin
      errors++; $display("FAIL fail5_clear: got %h expected 00", error); end
  endtask

  task automatic test_restart_lane0();
    force_en[0] = 1'b1; force_word[0] = 8'hF0; slips[0] = 0;
    pulse_start();
    steps(11);
    force_word[0] = 8'h0F;
    step();
    force_word[0] = 8'hF0;
    steps(19);
    checks++; if (aligned !== 8'hFE) begin
      errors++; $display("FAIL restart0_t31: got %h expected fe", aligned); end
    step();
    checks++; if (aligned !== 8'hFF || slips[0] !== 1) begin
      errors++; $display("FAIL restart0_t32: got al=%h slips=%0d expected ff 1", aligned, slips[0]); end
    step();
    checks++; if (data_valid !== 1'b1) begin
      errors++; $display("FAIL restart0_valid: got %b expected 1", data_valid); end
  endtask

  task automatic test_lock_loss();
    rx_locked[4] = 1'b0;
    step();
    checks++; if (aligned !== 8'hEF || all_aligned !== 1'b0) begin
      errors++; $display("FAIL lock4_drop: got al=%h aa=%b expected ef 0", aligned, all_aligned); end
    rx_locked[4] = 1'b1;
    step();
    checks++; if (data_valid !== 1'b0) begin
      errors++; $display("FAIL lock4_valid_fall: got %b expected 0", data_valid); end
    steps(15);
    checks++; if (aligned !== 8'hEF) begin
      errors++; $display("FAIL lock4_early: got %h expected ef", aligned); end
    step();
    checks++; if (aligned !== 8'hFF || data_valid !== 1'b0) begin
      errors++; $display("FAIL lock4_realign: got al=%h dv=%b expected ff 0", aligned, data_valid); end
    step();
    checks++; if (data_valid !== 1'b1) begin
      errors++; $display("FAIL lock4_valid_rise: got %b expected 1", data_valid); end
  endtask

  task automatic test_data_path();
    logic [N*8-1:0] expd;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) begin
        force_en[i] = 1'b1;
        force_word[i] = 8'($urandom_range(0, 255));
      end
      step();
      expd = prev_data;
      checks++; if (data_out !== expd || data_valid !== 1'b1) begin
        errors++; $display("FAIL data_path[%0d]: got do=%h dv=%b expected %h 1", v, data_out, data_valid, expd); end
    end
    for (int i = 0; i < N; i++) force_en[i] = 1'b0;
  endtask

  task automatic test_reset_mid_settle();
    need[1] = 2; slips[1] = 0;
    pulse_start();
    steps(4);
    ref_rst_n = 1'b0;
    #1;
    checks++; if (bitslip !== 8'h00 || aligned !== 8'h00 || error !== 8'h00 || all_aligned !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: got bs=%h al=%h er=%h aa=%b expected 00 00 00 0", bitslip, aligned, error, all_aligned); end
    checks++; if (data_out !== '0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_data: got do=%h dv=%b expected 0 0", data_out, data_valid); end
    @(negedge ref_clk);
    steps(2);
    ref_rst_n = 1'b1;
    steps(10);
    checks++; if (slips[1] !== 1 || aligned !== 8'h00 || error !== 8'h00) begin
      errors++; $display("FAIL rst_mid_idle: got slips=%0d al=%h er=%h expected 1 00 00", slips[1], aligned, error); end
  endtask

  initial begin
    ref_rst_n = 1'b0;
    start     = 1'b0;
    rx_locked = '1;
    lane_data = '0;
    prev_data = '0;
    for (int i = 0; i < N; i++) begin
      slips[i] = 0; need[i] = 0; last_slip[i] = -1;
      force_en[i] = 1'b0; force_word[i] = 8'h00;
    end
    @(negedge ref_clk);
    test_reset();
    test_all_aligned();
    test_slip_lane2();
    test_fail_lane5();
    test_restart_lane0();
    test_lock_loss();
    test_data_path();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
